// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated, byte-lane-masked data memory responder for the LSU data port
// Accepts one request at a time, counts wait states, then pulses busy low for the response cycle.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        error
);
  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [29:0]   lat_idx;
  logic [31:0]   lat_wdata;
  logic [3:0]    lat_be;
  logic          lat_rd;
  logic          lat_wr;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          unused_addr_lsbs;
  assign unused_addr_lsbs = ^addr[1:0];

  // In IDLE the request comes straight from the ports (needed when WAIT_STATES is 0);
  // afterwards only the copy latched at acceptance is used.
  logic [29:0] cur_idx;
  logic        cur_rd;
  logic        cur_wr;
  always_comb begin
    cur_idx = lat_idx;
    cur_rd  = lat_rd;
    cur_wr  = lat_wr;
    if (state == S_IDLE) begin
      cur_idx = addr[31:2];
      cur_rd  = ren;
      cur_wr  = wen;
    end
  end

  logic        cur_err;
  logic [31:0] cur_word;
  logic [31:0] resp_rdata;
  assign cur_err    = ({2'b00, cur_idx} >= 32'(DEPTH_WORDS)) | (cur_rd & cur_wr);
  assign cur_word   = mem[cur_idx[AW-1:0]];
  assign resp_rdata = (cur_rd && !cur_err) ? cur_word : 32'h0;

  logic go_resp;
  assign go_resp = (ren | wen) &&
                   (((state == S_IDLE) && (WAIT_STATES == 0)) ||
                    ((state == S_WAIT) && (cnt == CW'(1))));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      busy      <= 1'b1;
      rdata     <= 32'h0;
      error     <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_rd    <= 1'b0;
      lat_wr    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ren || wen) begin
            lat_idx   <= addr[31:2];
            lat_wdata <= wdata;
            lat_be    <= byte_en;
            lat_rd    <= ren;
            lat_wr    <= wen;
            cnt       <= CW'(WAIT_STATES);
            state     <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!ren && !wen) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= S_RESP;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          busy  <= 1'b1;
          rdata <= 32'h0;
          error <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
      if (go_resp) begin
        busy  <= 1'b0;
        rdata <= resp_rdata;
        error <= cur_err;
      end
    end
  end

  // The write lands on the clock edge that ends the response cycle; a reset there discards it.
  always_ff @(posedge CLK) begin
    if (!RST && (state == S_RESP) && lat_wr && !cur_err) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) mem[lat_idx[AW-1:0]][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end
endmodule
